// File: rtl/ristretto_dmem_responder.sv
// Data-memory responder for the LSU read/write ports: one transaction at a time, byte-lane shifted.
// Optional range checking with error reporting is enabled by defining RISTRETTO_DMEM_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | sample requests, read wins over write
// ACK   | ready pulse for the latched transaction
// WAIT  | latency down-counter running
// RESP  | valid pulse; read data registered / write committed on entry
module ristretto_dmem_responder #(
  parameter int                      DataWidth     = 32,
  parameter int                      AddressWidth  = 32,
  parameter int                      MemDepthWords = 1024,
  parameter logic [AddressWidth-1:0] BaseAddr      = '0,
  parameter int                      RespLatency   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rd_req_i,
  input  logic [AddressWidth-1:0] rd_addr_i,
  input  logic [DataWidth/8-1:0]  rd_strb_i,
  output logic                    rd_ready_o,
  output logic                    rd_valid_o,
  output logic [DataWidth-1:0]    rd_data_o,
  input  logic                    wr_req_i,
  input  logic [AddressWidth-1:0] wr_addr_i,
  input  logic [DataWidth/8-1:0]  wr_strb_i,
  input  logic [DataWidth-1:0]    wr_data_i,
  output logic                    wr_ready_o,
  output logic                    wr_valid_o,
  output logic                    err_o
);
  localparam int StrbWidth  = DataWidth / 8;
  localparam int LaneWidth  = $clog2(StrbWidth);
  localparam int IndexWidth = $clog2(MemDepthWords);
  localparam logic [3:0] LatInit = 4'(RespLatency - 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    is_rd_q;
  logic [AddressWidth-1:0] addr_q;
  logic [StrbWidth-1:0]    strb_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [3:0]              cnt_q;

  logic [AddressWidth-1:0] offset;
  logic [IndexWidth-1:0]   word_idx;
  logic [LaneWidth-1:0]    lane;
  logic                    out_of_range;
  logic                    enter_resp;
  logic [DataWidth-1:0]    rd_shift, rd_masked, wr_data_sh;
  logic [StrbWidth-1:0]    wr_strb_sh;

  logic [DataWidth-1:0] mem [MemDepthWords];

  assign offset   = addr_q - BaseAddr;
  assign word_idx = offset[IndexWidth+LaneWidth-1:LaneWidth];
  assign lane     = offset[LaneWidth-1:0];

`ifdef RISTRETTO_DMEM_RANGE_CHECK_EN
  localparam logic [AddressWidth:0] MemBytes = (AddressWidth+1)'(MemDepthWords * StrbWidth);
  assign out_of_range = (addr_q < BaseAddr) || ({1'b0, offset} >= MemBytes);
`else
  // Upper offset bits are deliberately ignored so the index wraps.
  logic unused_offset;
  assign unused_offset = ^offset;
  assign out_of_range  = 1'b0;
`endif

  assign rd_shift   = mem[word_idx] >> {lane, 3'b000};
  assign wr_strb_sh = strb_q << lane;
  assign wr_data_sh = wdata_q << {lane, 3'b000};

  always_comb begin
    rd_masked = '0;
    for (int b = 0; b < StrbWidth; b++) begin
      if (strb_q[b]) rd_masked[8*b +: 8] = rd_shift[8*b +: 8];
    end
  end

  assign enter_resp = (state_d == RESP) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rd_req_i || wr_req_i) state_d = ACK;
      ACK:  state_d = (RespLatency == 1) ? RESP : WAIT;
      WAIT: if (cnt_q == 4'd1) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ready_o = (state_q == ACK)  &&  is_rd_q;
    wr_ready_o = (state_q == ACK)  && !is_rd_q;
    rd_valid_o = (state_q == RESP) &&  is_rd_q;
    wr_valid_o = (state_q == RESP) && !is_rd_q;
    err_o      = (state_q == RESP) && out_of_range;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_data_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req_i) begin
            is_rd_q <= 1'b1;
            addr_q  <= rd_addr_i;
            strb_q  <= rd_strb_i;
          end else if (wr_req_i) begin
            is_rd_q <= 1'b0;
            addr_q  <= wr_addr_i;
            strb_q  <= wr_strb_i;
            wdata_q <= wr_data_i;
          end
        end
        ACK:     cnt_q <= LatInit;
        WAIT:    cnt_q <= cnt_q - 4'd1;
        default: ;
      endcase
      if (enter_resp && is_rd_q) rd_data_o <= out_of_range ? '0 : rd_masked;
    end
  end

  // Array is not reset; writes land only when the response is actually issued.
  always_ff @(posedge clk_i) begin
    if (enter_resp && !is_rd_q && !out_of_range) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (wr_strb_sh[b]) mem[word_idx][8*b +: 8] <= wr_data_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ristretto_dmem_responder.sv
// Bench for ristretto_dmem_responder: two instances (latency 1 and 4), table-driven
// transactions with a response scoreboard, plus arbitration and reset-abort sequences.
module tb_ristretto_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [1:0]             rd_req, wr_req;
  logic [1:0][31:0]       rd_addr, wr_addr, wr_data;
  logic [1:0][3:0]        rd_strb, wr_strb;
  wire  [1:0]             rd_ready, rd_valid, wr_ready, wr_valid, err;
  wire  [1:0][31:0]       rd_data;

  ristretto_dmem_responder #(.RespLatency(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req[0]), .rd_addr_i(rd_addr[0]), .rd_strb_i(rd_strb[0]),
    .rd_ready_o(rd_ready[0]), .rd_valid_o(rd_valid[0]), .rd_data_o(rd_data[0]),
    .wr_req_i(wr_req[0]), .wr_addr_i(wr_addr[0]), .wr_strb_i(wr_strb[0]), .wr_data_i(wr_data[0]),
    .wr_ready_o(wr_ready[0]), .wr_valid_o(wr_valid[0]), .err_o(err[0])
  );

  ristretto_dmem_responder #(.RespLatency(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req[1]), .rd_addr_i(rd_addr[1]), .rd_strb_i(rd_strb[1]),
    .rd_ready_o(rd_ready[1]), .rd_valid_o(rd_valid[1]), .rd_data_o(rd_data[1]),
    .wr_req_i(wr_req[1]), .wr_addr_i(wr_addr[1]), .wr_strb_i(wr_strb[1]), .wr_data_i(wr_data[1]),
    .wr_ready_o(wr_ready[1]), .wr_valid_o(wr_valid[1]), .err_o(err[1])
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;     // write data, or expected read data
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          d;
    bit          is_rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  task automatic add(input bit r, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] dt, input logic er);
    vec_t v;
    v.is_rd = r; v.addr = a; v.strb = s; v.data = dt; v.exp_err = er;
    tbl.push_back(v);
  endtask

  // Response monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rd_valid[d] || wr_valid[d]) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(rd_valid[d] | wr_valid[d]), 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_instance", 32'(d), 32'(e.d));
          check("resp_is_read", 32'(rd_valid[d]), 32'(e.is_rd));
          check("resp_err", 32'(err[d]), 32'(e.err));
          if (e.is_rd) check("rd_data", rd_data[d], e.data);
        end
      end
    end
  end

  task automatic run_txn(input int d, input vec_t v);
    exp_t e;
    int   k, extra, lat;
    lat = (d == 0) ? 1 : 4;
    e.d = d; e.is_rd = v.is_rd; e.data = v.data; e.err = v.exp_err;
    sb.push_back(e);
    if (v.is_rd) begin
      rd_req[d] = 1'b1; rd_addr[d] = v.addr; rd_strb[d] = v.strb;
    end else begin
      wr_req[d] = 1'b1; wr_addr[d] = v.addr; wr_strb[d] = v.strb; wr_data[d] = v.data;
    end
    k = 0;
    do begin @(posedge clk); #1; k++; end
    while (!(rd_ready[d] | wr_ready[d]) && k < 20);
    check("ready_latency", k, 1);
    rd_req[d] = 1'b0; wr_req[d] = 1'b0;
    k = 0; extra = 0;
    do begin
      @(posedge clk); #1; k++;
      if (rd_ready[d] | wr_ready[d]) extra++;
    end while (!(rd_valid[d] | wr_valid[d]) && k < 40);
    check("valid_latency", k, lat);
    check("ready_single_pulse", extra, 0);
    @(posedge clk); #1;
    check("valid_single_pulse", 32'(rd_valid[d] | wr_valid[d]), 32'd0);
  endtask

  function automatic vec_t mk(input bit r, input logic [31:0] a, input logic [3:0] s, input logic [31:0] dt);
    vec_t v;
    v.is_rd = r; v.addr = a; v.strb = s; v.data = dt; v.exp_err = 1'b0;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   rd_at, wr_at, overlap, nval;

    add(0, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    add(1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    add(0, 32'h13, 4'h1, 32'h000000AB, 0);
    add(0, 32'h10, 4'h3, 32'h00001234, 0);
    add(1, 32'h10, 4'hF, 32'hABAD1234, 0);
    add(1, 32'h13, 4'h1, 32'h000000AB, 0);
    add(1, 32'h12, 4'h3, 32'h0000ABAD, 0);
    add(1, 32'h11, 4'h1, 32'h00000012, 0);
    add(0, 32'h20, 4'hF, 32'h11223344, 0);
    add(0, 32'h22, 4'h3, 32'h0000CAFE, 0);
    add(1, 32'h20, 4'hF, 32'hCAFE3344, 0);
    add(0, 32'h24, 4'hF, 32'h55667788, 0);
    add(0, 32'h23, 4'hF, 32'hA1B2C3D4, 0);   // crosses word boundary: only byte 3 lands
    add(1, 32'h20, 4'hF, 32'hD4FE3344, 0);
    add(1, 32'h24, 4'hF, 32'h55667788, 0);
    add(1, 32'h22, 4'hF, 32'h0000D4FE, 0);
    add(0, 32'h24, 4'h0, 32'hFFFFFFFF, 0);
    add(1, 32'h24, 4'hF, 32'h55667788, 0);
    add(1, 32'h24, 4'h0, 32'h00000000, 0);
    add(0, 32'h00, 4'hF, 32'h0BADF00D, 0);
    add(1, 32'h02, 4'h3, 32'h00000BAD, 0);
`ifdef RISTRETTO_DMEM_RANGE_CHECK_EN
    add(1, 32'h1000, 4'hF, 32'h00000000, 1);
`else
    add(1, 32'h1000, 4'hF, 32'h0BADF00D, 0);
`endif

    rst = 1'b1;
    rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0; rd_strb = '0; wr_strb = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_handshake", 32'({rd_ready[d], rd_valid[d], wr_ready[d], wr_valid[d], err[d]}), 32'd0);
      check("reset_rd_data", rd_data[d], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_txn(0, tbl[i]);

    // Simultaneous requests: read first, write accepted on the following IDLE.
    e.d = 0; e.is_rd = 1'b1; e.data = 32'hABAD1234; e.err = 1'b0; sb.push_back(e);
    e.is_rd = 1'b0; e.data = '0; sb.push_back(e);
    rd_req[0] = 1'b1; rd_addr[0] = 32'h10; rd_strb[0] = 4'hF;
    wr_req[0] = 1'b1; wr_addr[0] = 32'h30; wr_strb[0] = 4'hF; wr_data[0] = 32'h5A5A5A5A;
    rd_at = 0; wr_at = 0; overlap = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (rd_ready[0] && wr_ready[0]) overlap++;
      if (rd_ready[0]) begin if (rd_at == 0) rd_at = c; rd_req[0] = 1'b0; end
      if (wr_ready[0]) begin if (wr_at == 0) wr_at = c; wr_req[0] = 1'b0; end
    end
    rd_req[0] = 1'b0; wr_req[0] = 1'b0;
    check("arb_rd_ready_cycle", rd_at, 1);
    check("arb_wr_ready_cycle", wr_at, 4);
    check("arb_ready_overlap", overlap, 0);
    run_txn(0, mk(1, 32'h30, 4'hF, 32'h5A5A5A5A));

    // Latency 4 instance, then a write abandoned by reset while in WAIT.
    run_txn(1, mk(0, 32'h20, 4'hF, 32'h11111111));
    run_txn(1, mk(1, 32'h20, 4'hF, 32'h11111111));
    wr_req[1] = 1'b1; wr_addr[1] = 32'h20; wr_strb[1] = 4'hF; wr_data[1] = 32'h22222222;
    @(posedge clk); #1;
    check("abort_wr_ready", 32'(wr_ready[1]), 32'd1);
    wr_req[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_handshake_zero", 32'({rd_ready[1], rd_valid[1], wr_ready[1], wr_valid[1], err[1]}), 32'd0);
    check("abort_rd_data_zero", rd_data[1], 32'd0);
    nval = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rd_valid[1] | wr_valid[1] | rd_ready[1] | wr_ready[1]) nval++;
    end
    check("abort_no_activity", nval, 0);
    run_txn(1, mk(1, 32'h20, 4'hF, 32'h11111111));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
